// File: rtl/chan_switch_pkg.sv
// Shared types, defaults and helpers for the channel switch.
// Optional build macro: CHAN_SWITCH_HOLD_EN (hold data_out during blanking).
package chan_switch_pkg;

    typedef enum logic {
        ACTIVE = 1'b0,
        BLANK  = 1'b1
    } cs_state_t;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_DEAD_CYCLES = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/chan_switch_deadtime.sv
// Dead-time down counter used while the switch is blanking.
// Optional build macro: CHAN_SWITCH_HOLD_EN (not used in this file).
module chan_switch_deadtime (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       done
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count == 8'd0);

endmodule

// File: rtl/chan_switch.sv
// Glitch-free channel switch with dead-time blanking between channels.
// Optional build macro: CHAN_SWITCH_HOLD_EN (hold last word during blanking).
import chan_switch_pkg::*;

module chan_switch #(
    parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter  int NUM_CH      = DEF_NUM_CH,
    parameter  int DEAD_CYCLES = DEF_DEAD_CYCLES,
    localparam int CH_W        = clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic [CH_W-1:0]              sel_in,
    input  logic                         sel_valid,
    output logic                         sel_ready,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         out_valid,
    output logic [CH_W-1:0]              cur_sel,
    output logic                         busy,
    output logic                         err_bad_sel
);

    localparam logic [CH_W:0] NUM_CH_V  = (CH_W + 1)'(NUM_CH);
    localparam logic [7:0]    DEAD_LOAD = 8'(DEAD_CYCLES - 1);

    cs_state_t       state;
    logic [CH_W-1:0] pending;
    logic            accept;
    logic            bad_sel;
    logic            do_switch;
    logic            dt_done;
    logic [DATA_WIDTH-1:0] mux_word;

    assign sel_ready = (state == ACTIVE);
    assign busy      = (state == BLANK);
    assign accept    = sel_valid && sel_ready;
    assign bad_sel   = ({1'b0, sel_in} >= NUM_CH_V);
    assign do_switch = accept && !bad_sel && (sel_in != cur_sel);
    assign mux_word  = data_in[int'(cur_sel)*DATA_WIDTH +: DATA_WIDTH];

    chan_switch_deadtime u_deadtime (
        .clk      (clk),
        .rst      (rst),
        .load     (do_switch),
        .load_val (DEAD_LOAD),
        .dec      (busy),
        .done     (dt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ACTIVE;
            cur_sel     <= '0;
            pending     <= '0;
            data_out    <= '0;
            out_valid   <= 1'b0;
            err_bad_sel <= 1'b0;
        end else begin
            err_bad_sel <= accept && bad_sel;
            unique case (state)
                ACTIVE: begin
                    if (do_switch) begin
                        pending   <= sel_in;
                        out_valid <= 1'b0;
                        state     <= BLANK;
`ifndef CHAN_SWITCH_HOLD_EN
                        data_out  <= '0;
`endif
                    end else begin
                        data_out  <= mux_word;
                        out_valid <= 1'b1;
                    end
                end
                BLANK: begin
                    // data_out is left as-is: held word or the zero forced on entry
                    out_valid <= 1'b0;
                    if (dt_done) begin
                        cur_sel <= pending;
                        state   <= ACTIVE;
                    end
                end
            endcase
        end
    end

endmodule
